// File: rtl/cmd_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatch_pkg
// Description : Shared types and constants for the command dispatcher.
//               Provides the sequencer state encoding, the status byte
//               values returned over the UART, the command field positions
//               and a helper that selects the command bytes echoed back
//               after the status byte.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_dispatch_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        RESP     = 3'd4,
        WAIT_TX  = 3'd5
    } state_t;

    // Status bytes returned to the host
    localparam logic [7:0] ST_OK     = 8'hA5;
    localparam logic [7:0] ST_BADTGT = 8'hE1;
    localparam logic [7:0] ST_ERR    = 8'hE2;
    localparam logic [7:0] ST_TMO    = 8'hE3;

    // Command field positions
    localparam int TGT_MSB = 23;
    localparam int TGT_LSB = 22;
    localparam int OP_MSB  = 21;
    localparam int OP_LSB  = 16;

    // Echo byte n (0..2) is the command, most significant byte first.
    function automatic logic [7:0] echo_byte(input logic [23:0] cmd_q,
                                             input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = cmd_q[23:16];
            2'd1:    b = cmd_q[15:8];
            2'd2:    b = cmd_q[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_dispatch_timer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_timeout_timer
// Description : Saturating cycle counter that bounds one target transaction.
//               The count is cleared by clr, advances while en is high and
//               stops at TIMEOUT_CYC (never wraps). expired is high while the
//               count equals TIMEOUT_CYC-1, i.e. on the last permitted wait
//               cycle.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               clr          - zero the count
//               en           - advance the count
//               expired      - last wait cycle reached
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SAT   = c_CNT_W'(TIMEOUT_CYC);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_SAT)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatch
// Description : Command sequencer between the UART command assembler and the
//               datapath targets. Latches one 24-bit command, issues it to the
//               addressed target over a level req / pulse ack-err handshake,
//               bounds the wait with a timeout and returns a status byte over
//               the UART transmitter. Only one command is in flight.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               cmd_rdy, cmd, clr_cmd_rdy - command intake
//               tgt_req/op/data, tgt_ack/err - target handshake
//               trmt, tx_data, tx_done  - UART transmit handshake
//               busy                    - sequencer not idle
// Options     : CMD_DISPATCH_ECHO_EN - when defined, the three command bytes
//               are transmitted after the status byte (4 bytes total).
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int NUM_TGT     = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_rdy,
    input  logic [23:0]        cmd,
    output logic               clr_cmd_rdy,
    output logic [NUM_TGT-1:0] tgt_req,
    output logic [5:0]         tgt_op,
    output logic [15:0]        tgt_data,
    input  logic [NUM_TGT-1:0] tgt_ack,
    input  logic [NUM_TGT-1:0] tgt_err,
    output logic               trmt,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [23:0]        r_cmd_q;
    logic [NUM_TGT-1:0] r_tgt_req;
    logic [5:0]         r_tgt_op;
    logic [15:0]        r_tgt_data;
    logic [7:0]         r_tx_data;

    logic [1:0]         w_idx;
    logic [NUM_TGT-1:0] w_onehot;
    logic               w_bad_tgt;
    logic               w_sel_ack;
    logic               w_sel_err;
    logic               w_expired;

    logic               w_latch;
    logic               w_issue;
    logic               w_drop;
    logic               w_timer_en;
    logic               w_tx_ld;
    logic [7:0]         w_tx_val;
    logic               w_trmt;

`ifdef CMD_DISPATCH_ECHO_EN
    // Counts bytes already sent for this command: 0 = status byte.
    logic [1:0]         r_byte_cnt;
    logic               w_byte_adv;
`endif

    assign w_idx     = r_cmd_q[TGT_MSB:TGT_LSB];
    assign w_bad_tgt = ({1'b0, w_idx} >= 3'(NUM_TGT));

    // Target decode; an out-of-range index yields no request bit at all.
    for (genvar g = 0; g < NUM_TGT; g++) begin : g_onehot
        assign w_onehot[g] = (w_idx == 2'(g));
    end

    // Only the selected target's responses count; others are masked off.
    assign w_sel_ack = |(tgt_ack & w_onehot);
    assign w_sel_err = |(tgt_err & w_onehot);

    cmd_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_issue),
        .en      (w_timer_en),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        w_timer_en  = 1'b0;
        w_tx_ld     = 1'b0;
        w_tx_val    = r_tx_data;
        w_trmt      = 1'b0;
`ifdef CMD_DISPATCH_ECHO_EN
        w_byte_adv  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (cmd_rdy) begin
                    w_latch     = 1'b1;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (w_bad_tgt) begin
                    w_tx_ld     = 1'b1;
                    w_tx_val    = ST_BADTGT;
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                w_timer_en = 1'b1;
                // Error beats ack, and either beats a same-cycle timeout.
                if (w_sel_err) begin
                    w_tx_ld     = 1'b1;
                    w_tx_val    = ST_ERR;
                    w_drop      = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_sel_ack) begin
                    w_tx_ld     = 1'b1;
                    w_tx_val    = ST_OK;
                    w_drop      = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_expired) begin
                    w_tx_ld     = 1'b1;
                    w_tx_val    = ST_TMO;
                    w_drop      = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_trmt      = 1'b1;
                w_state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
`ifdef CMD_DISPATCH_ECHO_EN
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_tx_ld     = 1'b1;
                        w_tx_val    = echo_byte(r_cmd_q, r_byte_cnt);
                        w_byte_adv  = 1'b1;
                        w_state_nxt = RESP;
                    end
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. The request is registered so it rises the cycle
    // after ISSUE and falls the cycle after the WAIT_ACK exit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_q    <= '0;
            r_tgt_req  <= '0;
            r_tgt_op   <= '0;
            r_tgt_data <= '0;
            r_tx_data  <= '0;
        end else begin
            if (w_latch) begin
                r_cmd_q <= cmd;
            end
            if (w_issue) begin
                r_tgt_req  <= w_onehot;
                r_tgt_op   <= r_cmd_q[OP_MSB:OP_LSB];
                r_tgt_data <= r_cmd_q[15:0];
            end else if (w_drop) begin
                r_tgt_req  <= '0;
            end
            if (w_tx_ld) begin
                r_tx_data <= w_tx_val;
            end
        end
    end

`ifdef CMD_DISPATCH_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
        end else if (w_latch) begin
            r_byte_cnt <= 2'd0;
        end else if (w_byte_adv) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end
`endif

    // Pulses are combinational from state; masked so nothing leaks out
    // during a reset cycle.
    assign clr_cmd_rdy = w_latch & ~rst;
    assign trmt        = w_trmt & ~rst;
    assign busy        = (r_state != IDLE);
    assign tgt_req     = r_tgt_req;
    assign tgt_op      = r_tgt_op;
    assign tgt_data    = r_tgt_data;
    assign tx_data     = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_dispatch
// Description : Self-checking bench for cmd_dispatch (TIMEOUT_CYC=16).
//               Main instance has 4 targets; a second 3-target instance
//               exercises the bad-target path. Expected UART bytes are queued
//               when a command is driven and compared when trmt fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_dispatch;

    localparam int c_TMO = 16;
`ifdef CMD_DISPATCH_ECHO_EN
    localparam int c_NBYTES = 4;
`else
    localparam int c_NBYTES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_rdy;
    logic [23:0] cmd;
    logic        clr_cmd_rdy;
    logic [3:0]  tgt_req;
    logic [5:0]  tgt_op;
    logic [15:0] tgt_data;
    logic [3:0]  tgt_ack;
    logic [3:0]  tgt_err;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;

    logic        cmd_rdy3;
    logic [23:0] cmd3;
    logic        clr3;
    logic [2:0]  tgt_req3;
    logic [5:0]  tgt_op3;
    logic [15:0] tgt_data3;
    logic [2:0]  tgt_ack3;
    logic [2:0]  tgt_err3;
    logic        trmt3;
    logic [7:0]  tx_data3;
    logic        tx_done3;
    logic        busy3;

    int n_cmp = 0;
    int n_bad = 0;
    int n_trmt = 0;
    int n_clr = 0;
    int n_early = 0;
    int n_unstable = 0;
    int tx_lat = 3;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    cmd_dispatch #(.NUM_TGT(4), .TIMEOUT_CYC(c_TMO)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .clr_cmd_rdy(clr_cmd_rdy), .tgt_req(tgt_req), .tgt_op(tgt_op),
        .tgt_data(tgt_data), .tgt_ack(tgt_ack), .tgt_err(tgt_err),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
    );

    cmd_dispatch #(.NUM_TGT(3), .TIMEOUT_CYC(c_TMO)) dut3 (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy3), .cmd(cmd3),
        .clr_cmd_rdy(clr3), .tgt_req(tgt_req3), .tgt_op(tgt_op3),
        .tgt_data(tgt_data3), .tgt_ack(tgt_ack3), .tgt_err(tgt_err3),
        .trmt(trmt3), .tx_data(tx_data3), .tx_done(tx_done3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] status, input logic [23:0] c);
        sb.push_back(status);
`ifdef CMD_DISPATCH_ECHO_EN
        sb.push_back(c[23:16]);
        sb.push_back(c[15:8]);
        sb.push_back(c[7:0]);
`endif
    endtask

    // Present a command in IDLE; it must be taken the same cycle.
    task automatic send_cmd(input logic [23:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        #1;
        check("clr_same_cycle", clr_cmd_rdy, 1);
        tick();
        cmd_rdy = 1'b0;
    endtask

    task automatic wait_req(input int idx, output int cyc);
        cyc = 0;
        while (tgt_req[idx] !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("req_rise", tgt_req[idx], 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    // UART transmitter model: scoreboard compare at each trmt, then tx_done
    // after tx_lat cycles, watching for early trmt / unstable tx_data.
    initial begin : uart_model
        logic [7:0] held;
        logic [8:0] exp;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt === 1'b1) begin
                n_trmt++;
                exp = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100;
                check("tx_data", {23'd0, 1'b0, tx_data}, {23'd0, exp});
                held = tx_data;
                repeat (tx_lat) begin
                    @(negedge clk);
                    if (trmt === 1'b1) n_early++;
                    if (tx_data !== held) n_unstable++;
                end
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (clr_cmd_rdy === 1'b1) n_clr++;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        int t_trmt;
        int t_clr;
        int early;
        int saw_req;
        int saw_trmt;
        logic [7:0] got;

        rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; tgt_ack = '0; tgt_err = '0;
        cmd_rdy3 = 1'b0; cmd3 = '0; tgt_ack3 = '0; tgt_err3 = '0;
        tx_done3 = 1'b0;
        repeat (3) tick();
        cmd_rdy = 1'b1;
        #1;
        // ---- reset state ----
        check("rst_clr", clr_cmd_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_req", tgt_req, 0);
        check("rst_trmt", trmt, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_op_data", {tgt_op, tgt_data}, 0);
        cmd_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // ---- 1: target 1, ack 3 cycles after req ----
        t_trmt = n_trmt; t_clr = n_clr;
        push_exp(8'hA5, 24'h411234);
        send_cmd(24'h411234);
        check("t1_busy", busy, 1);
        wait_req(1, cyc);
        check("t1_req", tgt_req, 4'b0010);
        check("t1_op", tgt_op, 6'h01);
        check("t1_data", tgt_data, 16'h1234);
        repeat (3) tick();
        check("t1_req_hold", tgt_req, 4'b0010);
        tgt_ack = 4'b0010;
        tick();
        tgt_ack = '0;
        check("t1_req_drop", tgt_req, 0);
        check("t1_trmt_resp", trmt, 1);
        wait_idle();
        check("t1_trmt_cnt", n_trmt - t_trmt, c_NBYTES);
        check("t1_clr_cnt", n_clr - t_clr, 1);

        // ---- 2: bad target on the 3-target instance ----
        cmd3 = 24'hC00000;
        cmd_rdy3 = 1'b1;
        #1;
        check("t2_clr", clr3, 1);
        tick();
        cmd_rdy3 = 1'b0;
        saw_req = 0; saw_trmt = 0; got = '0;
        repeat (6) begin
            if (tgt_req3 !== 3'b000) saw_req++;
            if (trmt3 === 1'b1) begin
                saw_trmt++;
                got = tx_data3;
            end
            tick();
        end
        check("t2_no_req", saw_req, 0);
        check("t2_one_trmt", saw_trmt, 1);
        check("t2_status", got, 8'hE1);
        check("t2_busy_wait_tx", busy3, 1);
        tx_done3 = 1'b1;
        tick();
        tx_done3 = 1'b0;
`ifndef CMD_DISPATCH_ECHO_EN
        check("t2_idle", busy3, 0);
`endif

        // ---- 3: target 2 never responds -> timeout ----
        push_exp(8'hE3, 24'h8000FF);
        send_cmd(24'h8000FF);
        wait_req(2, cyc);
        cyc = 0;
        while (tgt_req[2] === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        check("t3_req_cycles", cyc, c_TMO);
        check("t3_req_low", tgt_req, 0);
        wait_idle();

        // ---- 4: stray ack ignored; ack+err together -> error ----
        push_exp(8'hE2, 24'h025A5A);
        send_cmd(24'h025A5A);
        wait_req(0, cyc);
        check("t4_op", tgt_op, 6'h02);
        tgt_ack = 4'b1000;
        tick();
        tgt_ack = '0;
        check("t4_stray", tgt_req, 4'b0001);
        tgt_ack = 4'b0001;
        tgt_err = 4'b0001;
        tick();
        tgt_ack = '0;
        tgt_err = '0;
        check("t4_req_drop", tgt_req, 0);
        wait_idle();

        // ---- 5: minimum latency, pending cmd_rdy, reset mid-wait ----
        tx_lat = 6;
        push_exp(8'hA5, 24'h7F0001);
        send_cmd(24'h7F0001);
        wait_req(1, cyc);
        check("t5_op", tgt_op, 6'h3F);
        tgt_ack = 4'b0010;
        tick();
        tgt_ack = '0;
        check("t5_min_latency", trmt, 1);
        tick();
        cmd = 24'h400007;
        cmd_rdy = 1'b1;
        early = 0; cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (clr_cmd_rdy === 1'b1) early++;
            tick();
            cyc++;
        end
        check("t5_no_early_latch", early, 0);
        check("t5_latch_at_idle", clr_cmd_rdy, 1);
        tick();
        cmd_rdy = 1'b0;
        wait_req(1, cyc);
        check("t5_data", tgt_data, 16'h0007);
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_req", tgt_req, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_trmt", trmt, 0);
        check("t5_rst_op", tgt_op, 0);
        check("t5_rst_tx", tx_data, 0);
        rst = 1'b0;
        tick();
        check("t5_post_trmt", trmt, 0);
        check("t5_post_busy", busy, 0);
        tx_lat = 3;

        // ---- 6: acked command; echo bytes follow when enabled ----
        t_trmt = n_trmt;
        push_exp(8'hA5, 24'h41ABCD);
        send_cmd(24'h41ABCD);
        wait_req(1, cyc);
        tick();
        tgt_ack = 4'b0010;
        tick();
        tgt_ack = '0;
        wait_idle();
        check("t6_trmt_cnt", n_trmt - t_trmt, c_NBYTES);

        repeat (10) tick();
        check("sb_drained", sb.size(), 0);
        check("trmt_before_done", n_early, 0);
        check("tx_data_stable", n_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
